pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports clk, rst_n: one clock; reset is synchronous and active-high (rst_n asserted high resets, sampled on clk rising edge).
REQ-002 SHALL have inputs: id_rs[2:0], id_rt[2:0] (ID source registers), id_uses_rs, id_uses_rt (1b each, source valid).
REQ-003 SHALL have inputs: ex_memread (1b, EX holds load), ex_rd[2:0] (EX load destination), br_taken (1b, EX branch/jump redirect).
REQ-004 SHALL have inputs: imem_busy, dmem_busy (1b each, cache miss in progress, level-held until done), halt_req (1b, HALT in MEM).
REQ-005 SHALL have outputs: pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall (1b each, drive register stall/wen=~stall).
REQ-006 SHALL have outputs: ifid_flush, idex_flush, memwb_bubble (1b each, load NOP/zero controls into register).
REQ-007 SHALL have outputs: state[2:0] (FSM state, debug), stall_cnt[15:0] (total stalled cycles).

Function
REQ-008 SHALL implement FSM states RUN, LDUSE, DWAIT, IWAIT, HALTED (encodings in package).
REQ-009 Load-use hazard SHALL be ex_memread & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
REQ-010 Event priority per cycle SHALL be: halt_req > dmem_busy > br_taken > load-use > imem_busy.
REQ-011 RUN, no event: all stall/flush/bubble outputs 0.
REQ-012 dmem_busy (any state except HALTED): pc/ifid/idex/exmem/memwb stall=1, memwb_bubble=0; next state DWAIT.
REQ-013 DWAIT SHALL hold all five stalls while dmem_busy=1; first cycle dmem_busy=0: memwb_bubble=1 for exactly that cycle, stalls 0, next RUN.
REQ-014 br_taken with no dmem_busy: ifid_flush=1, idex_flush=1, no stalls, one cycle; load-use in same cycle SHALL be ignored (squashed).
REQ-015 Load-use: pc_stall=1, ifid_stall=1, idex_flush=1 for exactly one cycle; state LDUSE for that cycle, next RUN.
REQ-016 LDUSE SHALL not re-detect on the cycle after (bubble now in EX, ex_memread=0 by construction).
REQ-017 imem_busy alone: pc_stall=1, ifid_flush=1 (bubble enters ID), downstream runs; state IWAIT until imem_busy=0, then RUN same cycle deassert.
REQ-018 imem_busy and dmem_busy together SHALL resolve to DWAIT; IWAIT re-entered afterwards if imem_busy persists.
REQ-019 br_taken during IWAIT SHALL assert ifid_flush and idex_flush; pc_stall stays 1 until imem_busy=0.
REQ-020 halt_req SHALL enter HALTED: all stalls=1 permanently until reset; flushes 0.
REQ-021 stall_cnt SHALL increment by 1 each cycle pc_stall=1, saturate at 16'hFFFF (no wrap).
REQ-022 Outputs SHALL be combinational from state and current inputs (zero-cycle latency); only state and stall_cnt are registered.

Reset
REQ-023 Reset SHALL force state=RUN, stall_cnt=0; during reset cycle all stall/flush outputs 0 except ifid_flush=1, idex_flush=1.
REQ-024 Reset mid-DWAIT/HALTED SHALL return to RUN on next edge regardless of dmem_busy.

Structure
REQ-025 State encodings and counter width SHALL live in shared package pipe_ctrl_pkg.
REQ-026 Load-use comparator SHALL be sub-module ld_use_detect; state and counter registers built from the codebase dff cell.

Verification
REQ-027 ex_memread=1, ex_rd=3, id_rs=3, id_uses_rs=1 -> one cycle pc_stall=ifid_stall=idex_flush=1, then all 0.
REQ-028 dmem_busy high 4 cycles -> 4 cycles all stalls=1, 5th cycle memwb_bubble=1, stall_cnt=4.
REQ-029 br_taken=1 with simultaneous load-use -> ifid_flush=idex_flush=1, pc_stall=0.
REQ-030 imem_busy and dmem_busy high, dmem drops after 2, imem after 5 -> DWAIT 2 cycles, bubble, IWAIT until cycle 5.
REQ-031 halt_req=1 then rst_n=1 one cycle -> HALTED held, then RUN, stall_cnt=0.
REQ-032 Force stall_cnt=16'hFFFE, stall 3 cycles -> stall_cnt=16'hFFFF, no wrap.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - controller FSM state encodings
//   - stall counter width and saturation value
//   - packed bundle of the eight per-cycle pipeline control bits
//   - saturating increment helper for the stall counter
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int STATE_W   = 3;
  localparam int CNT_W     = 16;
  localparam int REG_IDX_W = 3;

  // Encodings are visible on the debug state port, so keep them stable.
  typedef enum logic [STATE_W-1:0] {
    ST_RUN    = 3'd0,
    ST_LDUSE  = 3'd1,
    ST_DWAIT  = 3'd2,
    ST_IWAIT  = 3'd3,
    ST_HALTED = 3'd4
  } ctrl_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Per-cycle control bundle, MSB first in the order the stages appear.
  typedef struct packed {
    logic pc_stall;
    logic ifid_stall;
    logic idex_stall;
    logic exmem_stall;
    logic memwb_stall;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_bubble;
  } hazard_ctl_t;

  localparam hazard_ctl_t CTL_NONE = 8'b0000_0000;

  // Freeze the whole pipeline (data-cache miss or halted core).
  localparam hazard_ctl_t CTL_ALL_STALL = 8'b1111_1000;

  // Counter saturates at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/dff.sv
// -----------------------------------------------------------------------------
// dff
// Generic W-bit D flip-flop with synchronous active-high reset to RST_VAL.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active high
//   d    - next value
//   q    - registered value
// -----------------------------------------------------------------------------
module dff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Storage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/ld_use_detect.sv
// -----------------------------------------------------------------------------
// ld_use_detect
// Flags a load-use hazard: the instruction in EX is a load whose destination
// matches a source register actually read by the instruction in ID.
// Ports:
//   id_rs, id_rt          - ID source register indices
//   id_uses_rs/id_uses_rt - the corresponding source is really read
//   ex_memread            - EX holds a load
//   ex_rd                 - destination of the load in EX
//   hazard                - one-cycle stall required
// -----------------------------------------------------------------------------
module ld_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 ex_memread,
  input  logic [REG_IDX_W-1:0] ex_rd,
  output logic                 hazard
);

  logic rs_match_s;
  logic rt_match_s;

  // Register-index compare for each source operand, qualified by its use bit.
  always_comb begin
    rs_match_s = id_uses_rs & (id_rs == ex_rd);
    rt_match_s = id_uses_rt & (id_rt == ex_rd);
    hazard     = ex_memread & (rs_match_s | rt_match_s);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard / stall controller for a five-stage in-order pipeline. Decides each
// cycle which pipeline registers hold, which are flushed and when a bubble is
// pushed into MEM/WB, and counts the cycles the PC was held.
//
// Event priority inside one cycle:
//   halt_req > dmem_busy > br_taken > load-use > imem_busy
//
// Ports:
//   clk, rst_n          - clock; rst_n is an ACTIVE-HIGH synchronous reset
//   id_rs, id_rt        - ID source registers
//   id_uses_rs/_rt      - source valid flags
//   ex_memread, ex_rd   - load in EX and its destination
//   br_taken            - redirect resolved in EX
//   imem_busy/dmem_busy - instruction/data cache miss in progress
//   halt_req            - HALT reached MEM
//   *_stall             - hold the named register (wen = ~stall)
//   ifid_flush/idex_flush/memwb_bubble - load a NOP into the register
//   state               - FSM state (debug)
//   stall_cnt           - saturating count of cycles with pc_stall=1
//
// All control outputs are combinational from the registered state and the
// current inputs; only the state and the counter are flops.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 ex_memread,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 br_taken,
  input  logic                 imem_busy,
  input  logic                 dmem_busy,
  input  logic                 halt_req,
  output logic                 pc_stall,
  output logic                 ifid_stall,
  output logic                 idex_stall,
  output logic                 exmem_stall,
  output logic                 memwb_stall,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 memwb_bubble,
  output logic [STATE_W-1:0]   state,
  output logic [CNT_W-1:0]     stall_cnt
);

  // Despite its name, rst_n resets when high.
  logic rst_s;
  assign rst_s = rst_n;

  logic [STATE_W-1:0] state_q;
  ctrl_state_e        state_d;
  ctrl_state_e        cur_state_s;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [CNT_W-1:0]   stall_cnt_d;
  logic               ld_use_s;
  logic               iwait_hold_s;
  hazard_ctl_t        ctl_s;

  assign cur_state_s = ctrl_state_e'(state_q);

  ld_use_detect u_ld_use (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .hazard     (ld_use_s)
  );

  // While fetch is still waiting on the I-cache the PC cannot move, even if
  // a branch redirect is being taken in the same cycle.
  assign iwait_hold_s = (cur_state_s == ST_IWAIT) & imem_busy;

  // Next-state and per-cycle control decode.
  always_comb begin
    ctl_s   = CTL_NONE;
    state_d = ST_RUN;
    if (rst_s) begin
      // Reset empties the front end so nothing stale issues afterwards.
      ctl_s.ifid_flush = 1'b1;
      ctl_s.idex_flush = 1'b1;
      state_d          = ST_RUN;
    end else begin
      case (cur_state_s)
        ST_HALTED: begin
          ctl_s   = CTL_ALL_STALL;
          state_d = ST_HALTED;
        end
        ST_RUN, ST_LDUSE, ST_DWAIT, ST_IWAIT: begin
          if (halt_req) begin
            ctl_s   = CTL_ALL_STALL;
            state_d = ST_HALTED;
          end else if (dmem_busy) begin
            ctl_s   = CTL_ALL_STALL;
            state_d = ST_DWAIT;
          end else if (cur_state_s == ST_DWAIT) begin
            // Miss just resolved: pipeline restarts, and the MEM result that
            // was held must not be written back twice.
            ctl_s.memwb_bubble = 1'b1;
            state_d            = ST_RUN;
          end else if (br_taken) begin
            // Squashes wrong-path ID and EX, including any load-use there.
            ctl_s.ifid_flush = 1'b1;
            ctl_s.idex_flush = 1'b1;
            ctl_s.pc_stall   = iwait_hold_s;
            state_d          = iwait_hold_s ? ST_IWAIT : ST_RUN;
          end else if (ld_use_s && (cur_state_s != ST_LDUSE)) begin
            // In LDUSE the bubble sits in EX, so no second detection.
            ctl_s.pc_stall   = 1'b1;
            ctl_s.ifid_stall = 1'b1;
            ctl_s.idex_flush = 1'b1;
            state_d          = ST_LDUSE;
          end else if (imem_busy) begin
            // Hold the PC and feed bubbles into ID; downstream drains.
            ctl_s.pc_stall   = 1'b1;
            ctl_s.ifid_flush = 1'b1;
            state_d          = ST_IWAIT;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          // Unused encoding: recover to RUN with the front end flushed.
          ctl_s.ifid_flush = 1'b1;
          ctl_s.idex_flush = 1'b1;
          state_d          = ST_RUN;
        end
      endcase
    end
  end

  // Stall counter next value, saturating at all-ones.
  always_comb begin
    if (ctl_s.pc_stall) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  dff #(
    .W       (STATE_W),
    .RST_VAL (ST_RUN)
  ) u_state_ff (
    .clk (clk),
    .rst (rst_s),
    .d   (state_d),
    .q   (state_q)
  );

  dff #(
    .W       (CNT_W),
    .RST_VAL ({CNT_W{1'b0}})
  ) u_cnt_ff (
    .clk (clk),
    .rst (rst_s),
    .d   (stall_cnt_d),
    .q   (stall_cnt_q)
  );

  assign pc_stall     = ctl_s.pc_stall;
  assign ifid_stall   = ctl_s.ifid_stall;
  assign idex_stall   = ctl_s.idex_stall;
  assign exmem_stall  = ctl_s.exmem_stall;
  assign memwb_stall  = ctl_s.memwb_stall;
  assign ifid_flush   = ctl_s.ifid_flush;
  assign idex_flush   = ctl_s.idex_flush;
  assign memwb_bubble = ctl_s.memwb_bubble;
  assign state        = state_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed self-checking bench for pipe_hazard_ctrl. Inputs change on the
// falling edge; outputs are sampled 1 time unit later, well before the next
// rising edge. The control outputs are packed as
//   {pc,ifid,idex,exmem,memwb stall, ifid_flush, idex_flush, memwb_bubble}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam logic [2:0] S_RUN    = 3'd0;
  localparam logic [2:0] S_LDUSE  = 3'd1;
  localparam logic [2:0] S_DWAIT  = 3'd2;
  localparam logic [2:0] S_IWAIT  = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_ALL  = 8'b1111_1000;
  localparam logic [7:0] C_LDU  = 8'b1100_0010;
  localparam logic [7:0] C_BR   = 8'b0000_0110;
  localparam logic [7:0] C_IW   = 8'b1000_0100;
  localparam logic [7:0] C_IWBR = 8'b1000_0110;
  localparam logic [7:0] C_BUB  = 8'b0000_0001;
  localparam logic [7:0] C_RST  = 8'b0000_0110;

  logic        clk;
  logic        rst_n;
  logic [2:0]  id_rs;
  logic [2:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        ex_memread;
  logic [2:0]  ex_rd;
  logic        br_taken;
  logic        imem_busy;
  logic        dmem_busy;
  logic        halt_req;
  logic        pc_stall;
  logic        ifid_stall;
  logic        idex_stall;
  logic        exmem_stall;
  logic        memwb_stall;
  logic        ifid_flush;
  logic        idex_flush;
  logic        memwb_bubble;
  logic [2:0]  state;
  logic [15:0] stall_cnt;
  logic [7:0]  ctl;

  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .ex_memread   (ex_memread),
    .ex_rd        (ex_rd),
    .br_taken     (br_taken),
    .imem_busy    (imem_busy),
    .dmem_busy    (dmem_busy),
    .halt_req     (halt_req),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .idex_stall   (idex_stall),
    .exmem_stall  (exmem_stall),
    .memwb_stall  (memwb_stall),
    .ifid_flush   (ifid_flush),
    .idex_flush   (idex_flush),
    .memwb_bubble (memwb_bubble),
    .state        (state),
    .stall_cnt    (stall_cnt)
  );

  assign ctl = {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
                ifid_flush, idex_flush, memwb_bubble};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_rs      = 3'd0;
    id_rt      = 3'd0;
    id_uses_rs = 1'b0;
    id_uses_rt = 1'b0;
    ex_memread = 1'b0;
    ex_rd      = 3'd0;
    br_taken   = 1'b0;
    imem_busy  = 1'b0;
    dmem_busy  = 1'b0;
    halt_req   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    dmem_busy = 1'b1;
    #1;
    checks++;
    if (ctl !== C_RST) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RST);
    end
    @(negedge clk);
    #1;
    checks++;
    if (state !== S_RUN) begin
      errors++;
      $display("FAIL reset_state got=%0d exp=%0d", state, S_RUN);
    end
    checks++;
    if (stall_cnt !== 16'h0000) begin
      errors++;
      $display("FAIL reset_cnt got=%h exp=%h", stall_cnt, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (ctl !== C_NONE) begin
      errors++;
      $display("FAIL run_idle_ctl got=%b exp=%b", ctl, C_NONE);
    end
  endtask

  task automatic test_load_use();
    // {memread, ex_rd, rs, rt, uses_rs, uses_rt, hazard}
    logic [12:0] vec [6];
    vec[0] = {1'b1, 3'd3, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1};
    vec[1] = {1'b1, 3'd5, 3'd5, 3'd2, 1'b0, 1'b1, 1'b0};
    vec[2] = {1'b1, 3'd5, 3'd1, 3'd5, 1'b0, 1'b1, 1'b1};
    vec[3] = {1'b0, 3'd6, 3'd6, 3'd6, 1'b1, 1'b1, 1'b0};
    vec[4] = {1'b1, 3'd7, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0};
    vec[5] = {1'b1, 3'd0, 3'd0, 3'd4, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ex_memread = vec[i][12];
      ex_rd      = vec[i][11:9];
      id_rs      = vec[i][8:6];
      id_rt      = vec[i][5:3];
      id_uses_rs = vec[i][2];
      id_uses_rt = vec[i][1];
      #1;
      checks++;
      if (ctl !== (vec[i][0] ? C_LDU : C_NONE)) begin
        errors++;
        $display("FAIL ldu_detect[%0d] got=%b exp=%b", i, ctl,
                 vec[i][0] ? C_LDU : C_NONE);
      end
      // Same inputs held one more cycle: no re-detection after a hit.
      @(negedge clk);
      #1;
      checks++;
      if (ctl !== C_NONE) begin
        errors++;
        $display("FAIL ldu_followup[%0d] got=%b exp=%b", i, ctl, C_NONE);
      end
      checks++;
      if (state !== (vec[i][0] ? S_LDUSE : S_RUN)) begin
        errors++;
        $display("FAIL ldu_state[%0d] got=%0d exp=%0d", i, state,
                 vec[i][0] ? S_LDUSE : S_RUN);
      end
      @(negedge clk);
      clear_inputs();
    end
    #1;
    checks++;
    if (stall_cnt !== 16'd3) begin
      errors++;
      $display("FAIL ldu_cnt got=%0d exp=%0d", stall_cnt, 16'd3);
    end
  endtask

  task automatic test_dmem();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      dmem_busy = (i < 4);
      #1;
      checks++;
      if (ctl !== ((i < 4) ? C_ALL : ((i == 4) ? C_BUB : C_NONE))) begin
        errors++;
        $display("FAIL dmem_ctl[%0d] got=%b exp=%b", i, ctl,
                 (i < 4) ? C_ALL : ((i == 4) ? C_BUB : C_NONE));
      end
      checks++;
      if (state !== (((i == 0) || (i == 5)) ? S_RUN : S_DWAIT)) begin
        errors++;
        $display("FAIL dmem_state[%0d] got=%0d exp=%0d", i, state,
                 ((i == 0) || (i == 5)) ? S_RUN : S_DWAIT);
      end
    end
    checks++;
    if (stall_cnt !== 16'd4) begin
      errors++;
      $display("FAIL dmem_cnt got=%0d exp=%0d", stall_cnt, 16'd4);
    end
  endtask

  task automatic test_branch();
    do_reset();
    @(negedge clk);
    br_taken   = 1'b1;
    ex_memread = 1'b1;
    ex_rd      = 3'd2;
    id_rt      = 3'd2;
    id_uses_rt = 1'b1;
    #1;
    checks++;
    if (ctl !== C_BR) begin
      errors++;
      $display("FAIL br_squash_ldu got=%b exp=%b", ctl, C_BR);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if ((ctl !== C_NONE) || (state !== S_RUN)) begin
      errors++;
      $display("FAIL br_after got=%b/%0d exp=%b/%0d", ctl, state, C_NONE, S_RUN);
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL br_cnt got=%0d exp=%0d", stall_cnt, 16'd0);
    end
  endtask

  task automatic test_imem_dmem();
    logic [7:0] ec [7];
    logic [2:0] es [7];
    ec = '{C_ALL, C_ALL, C_BUB, C_IW, C_IW, C_NONE, C_NONE};
    es = '{S_RUN, S_DWAIT, S_DWAIT, S_RUN, S_IWAIT, S_IWAIT, S_RUN};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      dmem_busy = (i < 2);
      imem_busy = (i < 5);
      #1;
      checks++;
      if ((ctl !== ec[i]) || (state !== es[i])) begin
        errors++;
        $display("FAIL imem_dmem[%0d] got=%b/%0d exp=%b/%0d", i, ctl, state,
                 ec[i], es[i]);
      end
    end
    checks++;
    if (stall_cnt !== 16'd4) begin
      errors++;
      $display("FAIL imem_dmem_cnt got=%0d exp=%0d", stall_cnt, 16'd4);
    end
  endtask

  task automatic test_imem_branch();
    logic [7:0] ec [6];
    logic [2:0] es [6];
    ec = '{C_IW, C_IW, C_IWBR, C_IW, C_NONE, C_NONE};
    es = '{S_RUN, S_IWAIT, S_IWAIT, S_IWAIT, S_IWAIT, S_RUN};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      imem_busy = (i < 4);
      br_taken  = (i == 2);
      #1;
      checks++;
      if ((ctl !== ec[i]) || (state !== es[i])) begin
        errors++;
        $display("FAIL imem_br[%0d] got=%b/%0d exp=%b/%0d", i, ctl, state,
                 ec[i], es[i]);
      end
    end
    checks++;
    if (stall_cnt !== 16'd4) begin
      errors++;
      $display("FAIL imem_br_cnt got=%0d exp=%0d", stall_cnt, 16'd4);
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      halt_req = (i == 0);
      br_taken = (i == 1);
      imem_busy = (i == 2);
      #1;
      checks++;
      if ((ctl !== C_ALL) || (state !== ((i == 0) ? S_RUN : S_HALTED))) begin
        errors++;
        $display("FAIL halt[%0d] got=%b/%0d exp=%b/%0d", i, ctl, state, C_ALL,
                 (i == 0) ? S_RUN : S_HALTED);
      end
    end
    checks++;
    if (stall_cnt !== 16'd2) begin
      errors++;
      $display("FAIL halt_cnt got=%0d exp=%0d", stall_cnt, 16'd2);
    end
    @(negedge clk);
    clear_inputs();
    rst_n     = 1'b1;
    dmem_busy = 1'b1;
    #1;
    checks++;
    if ((ctl !== C_RST) || (state !== S_HALTED)) begin
      errors++;
      $display("FAIL halt_rst got=%b/%0d exp=%b/%0d", ctl, state, C_RST, S_HALTED);
    end
    @(negedge clk);
    rst_n     = 1'b0;
    dmem_busy = 1'b0;
    #1;
    checks++;
    if ((ctl !== C_NONE) || (state !== S_RUN) || (stall_cnt !== 16'd0)) begin
      errors++;
      $display("FAIL halt_exit got=%b/%0d/%0d exp=%b/%0d/0", ctl, state,
               stall_cnt, C_NONE, S_RUN);
    end
    // Reset in the middle of a data miss returns straight to RUN.
    @(negedge clk);
    dmem_busy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n     = 1'b0;
    dmem_busy = 1'b0;
    #1;
    checks++;
    if ((ctl !== C_NONE) || (state !== S_RUN)) begin
      errors++;
      $display("FAIL dwait_rst got=%b/%0d exp=%b/%0d", ctl, state, C_NONE, S_RUN);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] ecnt [4];
    ecnt = '{16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    do_reset();
    @(negedge clk);
    force dut.stall_cnt_d = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.stall_cnt_d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dmem_busy = (i < 3);
      #1;
      checks++;
      if (stall_cnt !== ecnt[i]) begin
        errors++;
        $display("FAIL sat_cnt[%0d] got=%h exp=%h", i, stall_cnt, ecnt[i]);
      end
    end
    checks++;
    if (ctl !== C_BUB) begin
      errors++;
      $display("FAIL sat_bubble got=%b exp=%b", ctl, C_BUB);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_dmem();
    test_branch();
    test_imem_dmem();
    test_imem_branch();
    test_halt();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
